// File: rtl/cnt_arb_ctrl_if.sv
// Bus between the timing clients / counter and the round-robin counter arbiter.
interface cnt_arb_ctrl_if;
  logic [1:0] Req;
  logic [7:0] Len0;
  logic [7:0] Len1;
  logic [7:0] CntQ;
  logic [1:0] Gnt;
  logic [1:0] Done;
  logic       Busy;
  logic       Err;
  logic       CEP;
  logic       CET;
  logic       PE;
  logic [7:0] D;

  modport master (
    output Req, Len0, Len1, CntQ,
    input  Gnt, Done, Busy, Err, CEP, CET, PE, D
  );

  modport slave (
    input  Req, Len0, Len1, CntQ,
    output Gnt, Done, Busy, Err, CEP, CET, PE, D
  );
endinterface

// File: rtl/cnt_arb_ctrl.sv
// Two-requester round-robin controller for a shared mod-120 loadable counter.
// Optional watchdog on a stuck counter is enabled by defining CNT_ARB_WDOG_EN.
module cnt_arb_ctrl (
  input  logic          i_Clk,
  input  logic          i_MR,
  cnt_arb_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_gnt;
  logic [1:0] r_done;
  logic       r_busy;
  logic       r_pe;
  logic       r_g;
  logic       r_last;
  logic [7:0] r_lat;

  logic       w_anyReq;
  logic       w_winner;
  logic [7:0] w_lenSel;
  logic [7:0] w_lenClamp;
  logic       w_reqG;
  logic       w_hit;
  logic       w_abort;
  logic       w_wdogTrip;
  logic       w_cep;

  assign w_anyReq = |io_bus.Req;
  assign w_reqG   = io_bus.Req[r_g];
  assign w_hit    = (io_bus.CntQ == (r_lat - 8'd1));
  assign w_abort  = ((r_state == LOAD) || (r_state == RUN)) && !w_reqG;

  // On a tie the requester not served last wins.
  always_comb begin
    w_winner = io_bus.Req[1];
    if (io_bus.Req == 2'b11) w_winner = ~r_last;
  end

  assign w_lenSel = w_winner ? io_bus.Len1 : io_bus.Len0;

  always_comb begin
    w_lenClamp = w_lenSel;
    if (w_lenSel == 8'd0) w_lenClamp = 8'd1;
    else if (w_lenSel > 8'd120) w_lenClamp = 8'd120;
  end

`ifdef CNT_ARB_WDOG_EN
  logic [7:0] r_runCnt;
  logic       r_err;

  // Counts RUN cycles; 121 without a hit means the counter is not responding.
  always_ff @(posedge i_Clk) begin
    if (i_MR) begin
      r_runCnt <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_runCnt <= (r_state == RUN) ? r_runCnt + 8'd1 : 8'd0;
      if (w_wdogTrip) r_err <= 1'b1;
    end
  end

  assign w_wdogTrip = (r_state == RUN) && !w_hit && (r_runCnt == 8'd120);
  assign io_bus.Err = r_err;
`else
  assign w_wdogTrip = 1'b0;
  assign io_bus.Err = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_MR) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_anyReq) w_next = LOAD;
      LOAD: w_next = w_abort ? IDLE : RUN;
      RUN: begin
        if (w_abort || w_wdogTrip) w_next = IDLE;
        else if (w_hit)            w_next = DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Enables drop in the same cycle the count reaches its target or the request goes away.
  always_comb begin
    w_cep = (r_state == RUN) && !w_hit && w_reqG;
  end

  always_ff @(posedge i_Clk) begin
    if (i_MR) begin
      r_gnt  <= 2'b00;
      r_done <= 2'b00;
      r_busy <= 1'b0;
      r_pe   <= 1'b1;
      r_g    <= 1'b0;
      r_last <= 1'b1;
      r_lat  <= 8'd1;
    end else begin
      r_busy <= (w_next != IDLE);
      r_pe   <= (w_next != LOAD);
      r_done <= (w_next == DONE) ? (r_g ? 2'b10 : 2'b01) : 2'b00;
      if ((r_state == IDLE) && (w_next == LOAD)) begin
        r_g   <= w_winner;
        r_lat <= w_lenClamp;
        r_gnt <= w_winner ? 2'b10 : 2'b01;
      end else if (w_next == IDLE) begin
        r_gnt <= 2'b00;
      end
      if ((r_state != IDLE) && (w_next == IDLE)) r_last <= r_g;
    end
  end

  assign io_bus.Gnt  = r_gnt;
  assign io_bus.Done = r_done;
  assign io_bus.Busy = r_busy;
  assign io_bus.PE   = r_pe;
  assign io_bus.CEP  = w_cep;
  assign io_bus.CET  = w_cep;
  assign io_bus.D    = 8'h00;

endmodule

// File: tb/tb_cnt_arb_ctrl.sv
// Self-checking bench for cnt_arb_ctrl with a behavioural mod-120 counter and
// a per-cycle expected-output scoreboard.
module tb_cnt_arb_ctrl;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       pe;
    logic       cep;
    logic       err;
    logic       qv;
    logic [7:0] q;
  } exp_t;

  logic clk = 1'b0;
  logic mr;
  logic [7:0] cntQ = 8'h00;
  logic stuck = 1'b0;
  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   lastId = 1;

  always #5 clk = ~clk;

  cnt_arb_ctrl_if bus();

  cnt_arb_ctrl dut (
    .i_Clk  (clk),
    .i_MR   (mr),
    .io_bus (bus)
  );

  // Behavioural mod-120 counter driven by the controller's pins.
  always @(posedge clk) begin
    if (!bus.PE) cntQ <= bus.D;
    else if (bus.CEP && bus.CET && !stuck) cntQ <= (cntQ == 8'd119) ? 8'd0 : cntQ + 8'd1;
  end

  assign bus.CntQ = cntQ;

  function automatic exp_t mkRec(input logic [1:0] gnt, input logic [1:0] done,
                                 input logic busy, input logic pe, input logic cep,
                                 input logic err, input logic qv, input logic [7:0] q);
    exp_t r;
    r.gnt = gnt; r.done = done; r.busy = busy; r.pe = pe;
    r.cep = cep; r.err = err; r.qv = qv; r.q = q;
    return r;
  endfunction

  function automatic int clampLen(input int len);
    if (len == 0) return 1;
    if (len > 120) return 120;
    return len;
  endfunction

  function automatic int pickWinner(input logic [1:0] req);
    if (req == 2'b11) return (lastId == 1) ? 0 : 1;
    return req[1] ? 1 : 0;
  endfunction

  task automatic pushService(input int id, input int lat);
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    expQ.push_back(mkRec(oh, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int k = 0; k < lat; k++)
      expQ.push_back(mkRec(oh, 2'b00, 1'b1, 1'b1, (k != lat - 1), 1'b0, 1'b1, 8'(k)));
    expQ.push_back(mkRec(oh, oh, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'(lat - 1)));
    lastId = id;
  endtask

  task automatic pushIdle(input logic qv, input logic [7:0] q, input logic err);
    expQ.push_back(mkRec(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, err, qv, q));
  endtask

  task automatic test_reset;
    mr = 1'b1;
    bus.Req = 2'b00; bus.Len0 = 8'd0; bus.Len1 = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (bus.Gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset Gnt: got %b want 00", bus.Gnt); end
    checks++; if (bus.Done !== 2'b00) begin errors++; $display("[TB] FAIL reset Done: got %b want 00", bus.Done); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset Busy: got %b want 0", bus.Busy); end
    checks++; if (bus.PE !== 1'b1) begin errors++; $display("[TB] FAIL reset PE: got %b want 1", bus.PE); end
    checks++; if ({bus.CEP, bus.CET} !== 2'b00) begin errors++; $display("[TB] FAIL reset CEP/CET: got %b want 00", {bus.CEP, bus.CET}); end
    checks++; if (bus.D !== 8'h00) begin errors++; $display("[TB] FAIL reset D: got %h want 00", bus.D); end
    checks++; if (bus.Err !== 1'b0) begin errors++; $display("[TB] FAIL reset Err: got %b want 0", bus.Err); end
    mr = 1'b0;
    lastId = 1;
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL idle Busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_single;
    exp_t e;
    bus.Len0 = 8'd5;
    bus.Req  = 2'b01;
    pushService(pickWinner(2'b01), clampLen(5));
    pushIdle(1'b1, 8'd4, 1'b0);
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      bus.Len0 = 8'd77;
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET, bus.Err} !== {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep, e.err}) begin
        errors++;
        $display("[TB] FAIL single ctl {Gnt,Done,Busy,PE,CEP,CET,Err}: got %b want %b",
                 {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET, bus.Err}, {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep, e.err});
      end
      if (e.qv) begin
        checks++; if (cntQ !== e.q) begin errors++; $display("[TB] FAIL single CntQ: got %0d want %0d", cntQ, e.q); end
      end
      if (e.done != 2'b00) bus.Req = bus.Req & ~e.done;
    end
  endtask

  task automatic test_reset_mid_run;
    bus.Len0 = 8'd10;
    bus.Req  = 2'b01;
    repeat (4) @(negedge clk);
    checks++; if ({bus.Gnt, bus.Busy, bus.PE} !== 4'b0111) begin errors++; $display("[TB] FAIL midrun pre-reset {Gnt,Busy,PE}: got %b want 0111", {bus.Gnt, bus.Busy, bus.PE}); end
    mr = 1'b1;
    bus.Req = 2'b00;
    @(negedge clk);
    checks++; if (bus.Gnt !== 2'b00) begin errors++; $display("[TB] FAIL midrun Gnt: got %b want 00", bus.Gnt); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun Busy: got %b want 0", bus.Busy); end
    checks++; if (bus.PE !== 1'b1) begin errors++; $display("[TB] FAIL midrun PE: got %b want 1", bus.PE); end
    checks++; if (bus.CEP !== 1'b0) begin errors++; $display("[TB] FAIL midrun CEP: got %b want 0", bus.CEP); end
    checks++; if (bus.Done !== 2'b00) begin errors++; $display("[TB] FAIL midrun Done: got %b want 00", bus.Done); end
    mr = 1'b0;
    lastId = 1;
    @(negedge clk);
  endtask

  task automatic test_contention;
    exp_t e;
    int w;
    int doneCnt;
    doneCnt = 0;
    bus.Len0 = 8'd3;
    bus.Len1 = 8'd4;
    bus.Req  = 2'b11;
    for (int n = 0; n < 4; n++) begin
      w = pickWinner(2'b11);
      pushService(w, (w == 1) ? 4 : 3);
      pushIdle(1'b1, (w == 1) ? 8'd3 : 8'd2, 1'b0);
    end
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET, bus.Err} !== {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep, e.err}) begin
        errors++;
        $display("[TB] FAIL contention ctl {Gnt,Done,Busy,PE,CEP,CET,Err}: got %b want %b",
                 {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET, bus.Err}, {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep, e.err});
      end
      if (e.qv) begin
        checks++; if (cntQ !== e.q) begin errors++; $display("[TB] FAIL contention CntQ: got %0d want %0d", cntQ, e.q); end
      end
      if (e.done != 2'b00) begin
        doneCnt++;
        if (doneCnt == 4) bus.Req = 2'b00;
      end
    end
  endtask

  task automatic test_clamp;
    exp_t e;
    bus.Len1 = 8'd0;
    bus.Req  = 2'b10;
    pushService(pickWinner(2'b10), clampLen(0));
    pushIdle(1'b1, 8'd0, 1'b0);
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET} !== {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep}) begin
        errors++;
        $display("[TB] FAIL clamp0 ctl: got %b want %b", {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET}, {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep});
      end
      if (e.qv) begin
        checks++; if (cntQ !== e.q) begin errors++; $display("[TB] FAIL clamp0 CntQ: got %0d want %0d", cntQ, e.q); end
      end
      if (e.done != 2'b00) bus.Req = bus.Req & ~e.done;
    end
    bus.Len1 = 8'd200;
    bus.Req  = 2'b10;
    pushService(pickWinner(2'b10), clampLen(200));
    pushIdle(1'b1, 8'h77, 1'b0);
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET} !== {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep}) begin
        errors++;
        $display("[TB] FAIL clamp200 ctl: got %b want %b", {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.CET}, {e.gnt, e.done, e.busy, e.pe, e.cep, e.cep});
      end
      if (e.qv) begin
        checks++; if (cntQ !== e.q) begin errors++; $display("[TB] FAIL clamp200 CntQ: got %0d want %0d", cntQ, e.q); end
      end
      if (e.done != 2'b00) bus.Req = bus.Req & ~e.done;
    end
  endtask

  task automatic test_abort;
    exp_t e;
    bus.Len0 = 8'd10;
    bus.Len1 = 8'd2;
    bus.Req  = 2'b01;
    expQ.push_back(mkRec(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int k = 0; k < 3; k++)
      expQ.push_back(mkRec(2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'(k)));
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP} !== {e.gnt, e.done, e.busy, e.pe, e.cep}) begin
        errors++;
        $display("[TB] FAIL abort run ctl: got %b want %b", {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP}, {e.gnt, e.done, e.busy, e.pe, e.cep});
      end
      if (e.qv) begin
        checks++; if (cntQ !== e.q) begin errors++; $display("[TB] FAIL abort CntQ: got %0d want %0d", cntQ, e.q); end
      end
    end
    bus.Req = 2'b00;
    #1;
    checks++; if ({bus.CEP, bus.CET} !== 2'b00) begin errors++; $display("[TB] FAIL abort enables drop: got %b want 00", {bus.CEP, bus.CET}); end
    lastId = 0;
    pushIdle(1'b1, 8'd2, 1'b0);
    pushIdle(1'b1, 8'd2, 1'b0);
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP} !== {e.gnt, e.done, e.busy, e.pe, e.cep}) begin
        errors++;
        $display("[TB] FAIL abort idle ctl: got %b want %b", {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP}, {e.gnt, e.done, e.busy, e.pe, e.cep});
      end
      if (e.qv) begin
        checks++; if (cntQ !== e.q) begin errors++; $display("[TB] FAIL abort held CntQ: got %0d want %0d", cntQ, e.q); end
      end
    end
    bus.Req = 2'b11;
    pushService(pickWinner(2'b11), clampLen(2));
    pushIdle(1'b1, 8'd1, 1'b0);
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP} !== {e.gnt, e.done, e.busy, e.pe, e.cep}) begin
        errors++;
        $display("[TB] FAIL abort regrant ctl: got %b want %b", {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP}, {e.gnt, e.done, e.busy, e.pe, e.cep});
      end
      if (e.done != 2'b00) bus.Req = 2'b00;
    end
  endtask

`ifdef CNT_ARB_WDOG_EN
  task automatic test_watchdog;
    exp_t e;
    stuck = 1'b1;
    bus.Len0 = 8'd50;
    bus.Req  = 2'b01;
    expQ.push_back(mkRec(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int k = 0; k < 121; k++)
      expQ.push_back(mkRec(2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00));
    for (int k = 0; k < 4; k++) pushIdle(1'b1, 8'h00, 1'b1);
    while (expQ.size() > 0) begin
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if ({bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.Err} !== {e.gnt, e.done, e.busy, e.pe, e.cep, e.err}) begin
        errors++;
        $display("[TB] FAIL watchdog ctl {Gnt,Done,Busy,PE,CEP,Err}: got %b want %b",
                 {bus.Gnt, bus.Done, bus.Busy, bus.PE, bus.CEP, bus.Err}, {e.gnt, e.done, e.busy, e.pe, e.cep, e.err});
      end
      if (e.gnt == 2'b00) bus.Req = 2'b00;
    end
    lastId = 0;
    mr = 1'b1;
    @(negedge clk);
    checks++; if (bus.Err !== 1'b0) begin errors++; $display("[TB] FAIL watchdog Err after MR: got %b want 0", bus.Err); end
    mr = 1'b0;
    lastId = 1;
    stuck = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_reset_mid_run;
    test_contention;
    test_clamp;
    test_abort;
`ifdef CNT_ARB_WDOG_EN
    test_watchdog;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
